// File: rtl/fcs_pkg.sv
// fcs_pkg: shared CRC-32 constants, arbiter states and requester IDs
// for the TX/RX FCS arbiter slice.
package fcs_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam int REQ_TX = 0;
  localparam int REQ_RX = 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } state_t;

endpackage

// File: rtl/crc32_step.sv
// crc32_step: one 32-bit word through an MSB-first CRC-32 register,
// bit 31 of the word first, purely combinational.
module crc32_step
  import fcs_pkg::*;
#(
  parameter logic [31:0] POLY = CRC_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  function automatic logic [31:0] step(
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return r;
  endfunction

  assign crc_out = step(crc_in, data_in);

endmodule

// File: rtl/fcs_arbiter.sv
// fcs_arbiter: frame-level sharing of one CRC-32 engine between TX and RX.
// Optional res_match residue output: define FCS_ARB_RESIDUE_CHECK_EN.
module fcs_arbiter
  import fcs_pkg::*;
#(
  parameter logic [31:0] POLY   = CRC_POLY,
  parameter logic [31:0] INIT   = CRC_INIT,
  parameter logic [31:0] XOROUT = CRC_XOROUT,
  parameter int          LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [63:0]      req_data,
  input  logic [1:0]       req_last,
  output logic [1:0]       req_ready,
  output logic             busy,
  output logic             res_valid,
  output logic             res_id,
  output logic [31:0]      res_crc,
  output logic [LEN_W-1:0] res_len
`ifdef FCS_ARB_RESIDUE_CHECK_EN
  ,
  output logic             res_match
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic               owner_q;
  logic               rr_q;
  logic [31:0]        crc_q;
  logic [LEN_W-1:0]   cnt_q;

  logic               winner;
  logic               own_valid;
  logic               own_last;
  logic [31:0]        own_data;
  logic               accept;
  logic [31:0]        crc_next;
  logic [LEN_W-1:0]   cnt_next;

  assign winner    = (&req_valid) ? rr_q : req_valid[REQ_RX];
  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_data  = owner_q ? req_data[63:32] : req_data[31:0];
  assign accept    = (state_q == GRANT) && own_valid;
  assign cnt_next  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  crc32_step #(
    .POLY(POLY)
  ) u_step (
    .crc_in (crc_q),
    .data_in(own_data),
    .crc_out(crc_next)
  );

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (|req_valid) state_d = GRANT;
      end
      GRANT: begin
        req_ready[owner_q] = 1'b1;
        if (accept && own_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant owner, round-robin pointer and running CRC/count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      crc_q   <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        crc_q <= INIT;
        cnt_q <= '0;
        if (|req_valid) owner_q <= winner;
        if (&req_valid) rr_q <= ~winner;
      end else if (accept) begin
        crc_q <= crc_next;
        cnt_q <= cnt_next;
      end
    end
  end

  // Result registers, loaded on the last beat and held until the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_id    <= 1'b0;
      res_crc   <= '0;
      res_len   <= '0;
`ifdef FCS_ARB_RESIDUE_CHECK_EN
      res_match <= 1'b0;
`endif
    end else if (accept && own_last) begin
      res_id    <= owner_q;
      res_crc   <= crc_next ^ XOROUT;
      res_len   <= cnt_next;
`ifdef FCS_ARB_RESIDUE_CHECK_EN
      res_match <= (crc_next == CRC_RESIDUE);
`endif
    end
  end

endmodule

// File: tb/tb_fcs_arbiter.sv
// tb_fcs_arbiter: scoreboarded frame tests for fcs_arbiter, with a
// second LEN_W=2 instance sharing the stimulus for count saturation.
module tb_fcs_arbiter;

  typedef logic [31:0] wq_t[$];

  typedef struct {
    logic        id;
    int          len;
    logic [31:0] crc;
    logic        match;
  } exp_t;

  typedef struct {
    logic        id;
    int          n;
    logic [31:0] seed;
    int          len;
    int          len2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_last;

  logic [1:0]  req_ready, req_ready2;
  logic        busy, busy2;
  logic        res_valid, res_valid2;
  logic        res_id, res_id2;
  logic [31:0] res_crc, res_crc2;
  logic [15:0] res_len;
  logic [1:0]  res_len2;
`ifdef FCS_ARB_RESIDUE_CHECK_EN
  logic        res_match, res_match2;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  wq_t  none;

  always #5 clk = ~clk;

  fcs_arbiter u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .busy     (busy),
    .res_valid(res_valid),
    .res_id   (res_id),
    .res_crc  (res_crc),
    .res_len  (res_len)
`ifdef FCS_ARB_RESIDUE_CHECK_EN
    ,
    .res_match(res_match)
`endif
  );

  fcs_arbiter #(
    .LEN_W(2)
  ) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready2),
    .busy     (busy2),
    .res_valid(res_valid2),
    .res_id   (res_id2),
    .res_crc  (res_crc2),
    .res_len  (res_len2)
`ifdef FCS_ARB_RESIDUE_CHECK_EN
    ,
    .res_match(res_match2)
`endif
  );

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Whole-word form: xor the word in, then shift 32 times.
  function automatic logic [31:0] model_raw(input wq_t w);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (w[k]) begin
      c = c ^ w[k];
      repeat (32) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic push(input logic id, input wq_t w, input int len,
                      input int mexp);
    exp_t e;
    logic [31:0] r;
    r       = model_raw(w);
    e.id    = id;
    e.len   = len;
    e.crc   = r ^ 32'hFFFFFFFF;
    e.match = (mexp < 0) ? (r == 32'hC704DD7B) : mexp[0];
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    int   l2;
    forever begin
      @(negedge clk);
      if (res_valid || res_valid2)
        chk("dut2_valid", res_valid2, res_valid);
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", res_valid, 0);
        end else begin
          e  = sb.pop_front();
          l2 = (e.len > 3) ? 3 : e.len;
          chk("res_id", res_id, e.id);
          chk("res_len", res_len, e.len);
          chk("res_crc", res_crc, e.crc);
          chk("res_len_sat", res_len2, l2);
          chk("res_crc_w2", res_crc2, e.crc);
`ifdef FCS_ARB_RESIDUE_CHECK_EN
          chk("res_match", res_match, e.match);
`endif
        end
      end
    end
  endtask

  task automatic drive(input wq_t tx, input wq_t rx, input int rx_start,
                       input int gap_at, input int gap_len,
                       input int first);
    int       ti, ri, gap, cyc;
    logic     gap_on;
    logic [1:0] acc;
    ti = 0; ri = 0; gap = 0; cyc = 0;
    while ((ti < tx.size() || ri < rx.size()) && cyc < 400) begin
      @(negedge clk);
      gap_on = (ti == gap_at) && (gap < gap_len) && (ti < tx.size());
      req_valid[0]   = (ti < tx.size()) && !gap_on;
      req_data[31:0] = (ti < tx.size()) ? tx[ti] : 32'h0;
      req_last[0]    = (ti == tx.size() - 1);
      req_valid[1]   = (ri < rx.size()) && (cyc >= rx_start);
      req_data[63:32] = (ri < rx.size()) ? rx[ri] : 32'h0;
      req_last[1]    = (ri == rx.size() - 1);
      #1;
      if (gap_on) begin
        chk("gap_ready", req_ready, 2'b01);
        chk("gap_busy", busy, 1);
        gap++;
      end
      if (first == 0 && ti > 0 && ti < tx.size())
        chk("rx_held", req_ready[1], 0);
      if (first == 1 && ri > 0 && ri < rx.size())
        chk("tx_held", req_ready[0], 0);
      acc = req_valid & req_ready;
      @(posedge clk);
      if (acc[0]) ti++;
      if (acc[1]) ri++;
      cyc++;
    end
    chk("drive_timeout", cyc < 400, 1);
    @(negedge clk);
    req_valid = 2'b00;
    req_last  = 2'b00;
  endtask

  initial begin
    vec_t tbl[5];
    wq_t  w, a, b;
    logic [31:0] t1crc;
    logic        rdy;
    int          k, cyc;

    tbl[0] = '{id: 1'b0, n: 1, seed: 32'hA5A5_0001, len: 1, len2: 1};
    tbl[1] = '{id: 1'b1, n: 3, seed: 32'h1234_5678, len: 3, len2: 3};
    tbl[2] = '{id: 1'b0, n: 5, seed: 32'hDEAD_BEEF, len: 5, len2: 3};
    tbl[3] = '{id: 1'b1, n: 4, seed: 32'h0000_0000, len: 4, len2: 3};
    tbl[4] = '{id: 1'b0, n: 2, seed: 32'hFFFF_FFFF, len: 2, len2: 2};

    rst_n = 1'b0;
    req_valid = 2'b00;
    req_data  = '0;
    req_last  = 2'b00;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_crc", res_crc, 0);
    chk("rst_res_len", res_len, 0);
    chk("rst_busy_w2", busy2, 0);
    rst_n = 1'b1;

    // TX-only two-word frame with exact latency
    w = '{32'h31323334, 32'h35363738};
    push(1'b0, w, 2, -1);
    t1crc = model_raw(w) ^ 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 2'b01;
    req_data[31:0] = w[0];
    #1 chk("t1_ready_c0", req_ready, 2'b00);
    @(negedge clk);
    chk("t1_ready_c1", req_ready, 2'b01);
    chk("t1_busy_c1", busy, 1);
    @(negedge clk);
    chk("t1_valid_c2", res_valid, 0);
    req_data[31:0] = w[1];
    req_last = 2'b01;
    @(negedge clk);
    chk("t1_valid_c3", res_valid, 1);
    chk("t1_ready_c3", req_ready, 2'b00);
    req_valid = 2'b00;
    req_last  = 2'b00;
    @(negedge clk);
    chk("t1_valid_c4", res_valid, 0);
    repeat (2) @(negedge clk);
    chk("t1_crc_hold", res_crc, t1crc);

    // Contention from reset: TX first, then RX; repeat gives RX first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a = '{32'h11111111, 32'h22222222, 32'h33333333};
    b = '{32'hAAAA0000, 32'h5555FFFF};
    push(1'b0, a, 3, -1);
    push(1'b1, b, 2, -1);
    drive(a, b, 0, -1, 0, 0);
    repeat (3) @(negedge clk);
    push(1'b1, b, 2, -1);
    push(1'b0, a, 3, -1);
    drive(a, b, 0, -1, 0, 1);
    repeat (3) @(negedge clk);

    // Owner stalls for 5 cycles mid-frame while RX waits
    a = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    b = '{32'hCAFEF00D, 32'h8BADF00D};
    push(1'b0, a, 4, -1);
    push(1'b1, b, 2, -1);
    drive(a, b, 1, 2, 5, 0);
    repeat (3) @(negedge clk);

    // Reset after 3 of 6 beats: no result, next frame from INIT
    a = '{32'hF0F0F0F0, 32'h0F0F0F0F, 32'h12121212, 32'h34343434,
          32'h56565656, 32'h78787878};
    k = 0; cyc = 0;
    while (k < 3 && cyc < 50) begin
      @(negedge clk);
      req_valid = 2'b01;
      req_data[31:0] = a[k];
      req_last = 2'b00;
      #1 rdy = req_ready[0];
      @(posedge clk);
      if (rdy) k++;
      cyc++;
    end
    chk("rst_mid_beats", k, 3);
    @(negedge clk);
    req_data[31:0] = a[3];
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", req_ready, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", res_valid, 0);
    rst_n = 1'b1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    push(1'b0, a, 6, -1);
    drive(a, none, 0, -1, 0, -1);
    repeat (3) @(negedge clk);

`ifdef FCS_ARB_RESIDUE_CHECK_EN
    // Residue: RX frame carrying the FCS of a prior TX frame
    a = '{32'h48656C6C, 32'h6F2C2057, 32'h6F726C64};
    push(1'b0, a, 3, -1);
    drive(a, none, 0, -1, 0, -1);
    b = a;
    b.push_back(model_raw(a) ^ 32'hFFFFFFFF);
    push(1'b1, b, 4, 1);
    drive(none, b, 0, -1, 0, -1);
    b[0] = b[0] ^ 32'h1;
    push(1'b1, b, 4, 0);
    drive(none, b, 0, -1, 0, -1);
    repeat (3) @(negedge clk);
`endif

    // Table of single-requester frames, including count saturation
    for (int v = 0; v < 5; v++) begin
      w.delete();
      for (int i = 0; i < tbl[v].n; i++)
        w.push_back(tbl[v].seed ^ (i * 32'h9E3779B9));
      push(tbl[v].id, w, tbl[v].len, -1);
      if (tbl[v].len2 != ((tbl[v].len > 3) ? 3 : tbl[v].len))
        chk("tbl_len2", tbl[v].len2, tbl[v].len);
      if (tbl[v].id == 1'b0) drive(w, none, 0, -1, 0, -1);
      else drive(none, w, 0, -1, 0, -1);
      repeat (2) @(negedge clk);
    end

    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
